// File: rtl/decrypt_v1_if.sv
// Request/result bundle for the PRESENT-80 decryptor: key and ciphertext in,
// plaintext and status out.
interface decrypt_v1_if #(
    parameter int b = 64,
    parameter int k = 80
);
    logic         req;
    logic [k-1:0] K;
    logic [b-1:0] C;
    logic [b-1:0] M;
    logic         ack;
    logic         busy;

    modport master (output req, K, C, input M, ack, busy);
    modport slave  (input req, K, C, output M, ack, busy);
endinterface

// File: rtl/decrypt_v1.sv
// Iterative PRESENT-80 decryptor. The key schedule is first run forward to
// round key 32, then unwound one step per round while the state is decrypted.
module decrypt_v1 #(
    parameter int b = 64,
    parameter int k = 80,
    parameter int r = 31
) (
    input  logic         clk,
    input  logic         rst,
    decrypt_v1_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, KEYEXP, WHITEN, DEC, DONE} state_t;

    localparam logic [4:0] last_round = 5'(r);

    state_t       state, state_next;
    logic [k-1:0] kr, kr_next, kp;
    logic [b-1:0] s, s_next;
    logic [b-1:0] m_q, m_next;
    logic [4:0]   i, i_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
            4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
            4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
        endcase
    endfunction

    function automatic logic [79:0] key_fwd(input logic [79:0] x, input logic [4:0] rc);
        logic [79:0] t;
        t = {x[18:0], x[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [79:0] key_inv(input logic [79:0] x, input logic [4:0] rc);
        logic [79:0] t;
        t = x;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    // Forward pLayer moves bit j to 16j mod 63, so the inverse gathers from there.
    function automatic logic [63:0] inv_p(input logic [63:0] x);
        logic [63:0] t;
        for (int j = 0; j < 63; j++) t[j] = x[(16 * j) % 63];
        t[63] = x[63];
        return t;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] t;
        for (int n = 0; n < 16; n++) t[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kr    <= '0;
            s     <= '0;
            i     <= '0;
            m_q   <= '0;
        end else begin
            state <= state_next;
            kr    <= kr_next;
            s     <= s_next;
            i     <= i_next;
            m_q   <= m_next;
        end
    end

    always_comb begin
        state_next = state;
        kr_next    = kr;
        s_next     = s;
        i_next     = i;
        m_next     = m_q;
        kp         = key_inv(kr, i);
        case (state)
            IDLE: begin
                if (bus.req) begin
                    kr_next    = bus.K;
                    s_next     = bus.C;
                    i_next     = 5'd1;
                    state_next = KEYEXP;
                end
            end
            KEYEXP: begin
                kr_next = key_fwd(kr, i);
                i_next  = i + 5'd1;
                if (i == last_round) state_next = WHITEN;
            end
            WHITEN: begin
                s_next     = s ^ kr[79:16];
                i_next     = last_round;
                state_next = DEC;
            end
            DEC: begin
                s_next  = inv_s_layer(inv_p(s)) ^ kp[79:16];
                kr_next = kp;
                i_next  = i - 5'd1;
                if (i == 5'd1) begin
                    m_next     = s_next;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.M    = m_q;
    assign bus.ack  = (state == DONE);
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_decrypt_v1.sv
// Directed bench for decrypt_v1: known PRESENT-80 vectors, back-to-back jobs,
// ignored requests, reset abort and round-trips against a bench-side encryptor.
module tb_decrypt_v1;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc = 0;
    int   ack_count = 0;
    int   lat;
    int   acks_before;
    logic [79:0] rk;
    logic [63:0] rp;

    decrypt_v1_if bus ();
    decrypt_v1 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (bus.ack === 1'b1) ack_count++;
    end

    function automatic logic [3:0] enc_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] st, t;
        logic [79:0] kk;
        st = pt;
        kk = key;
        for (int rr = 1; rr <= 31; rr++) begin
            st = st ^ kk[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = enc_sbox(st[4*n +: 4]);
            for (int j = 0; j < 63; j++) st[(16 * j) % 63] = t[j];
            st[63] = t[63];
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = enc_sbox(kk[79:76]);
            kk[19:15] = kk[19:15] ^ rr[4:0];
        end
        return st ^ kk[79:16];
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [79:0] key, input logic [63:0] ct, input bit hold);
        @(negedge clk);
        bus.req = 1'b1;
        bus.K   = key;
        bus.C   = ct;
        @(negedge clk);
        acc = cyc;
        if (!hold) bus.req = 1'b0;
    endtask

    task automatic wait_ack(output int l);
        int n = 0;
        while (bus.ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        l = (n >= 200) ? -1 : (cyc - acc);
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b1;
        bus.K = '0;
        bus.C = 64'h5579c1387b228445;
        repeat (3) @(negedge clk);
        check("rst_busy", 80'(bus.busy), 80'd0);
        check("rst_ack", 80'(bus.ack), 80'd0);
        check("rst_M", 80'(bus.M), 80'd0);
        check("rst_kr", dut.kr, 80'd0);
        check("rst_i", 80'(dut.i), 80'd0);
        bus.req = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        start(80'h0, 64'h5579c1387b228445, 1'b0);
        check("k0_busy", 80'(bus.busy), 80'd1);
        wait_ack(lat);
        check("k0_lat", 80'(lat), 80'd63);
        check("k0_M", 80'(bus.M), 80'h0);
        check("k0_kr_roundtrip", dut.kr, 80'h0);
        @(negedge clk);
        check("k0_ack_pulse", 80'(bus.ack), 80'd0);
        check("k0_idle", 80'(bus.busy), 80'd0);

        start({80{1'b1}}, 64'he72c46c0f5945049, 1'b0);
        wait_ack(lat);
        check("k1_lat", 80'(lat), 80'd63);
        check("k1_M", 80'(bus.M), 80'h0);
        check("k1_kr_roundtrip", dut.kr, {80{1'b1}});

        // back-to-back with req held high; inputs change after acceptance
        start(80'h0, 64'ha112ffc72f68417b, 1'b1);
        bus.K = {80{1'b1}};
        bus.C = 64'h3333dcd3213210d2;
        wait_ack(lat);
        check("b2b_a_lat", 80'(lat), 80'd63);
        check("b2b_a_M", 80'(bus.M), 80'hffffffffffffffff);
        @(negedge clk);
        check("b2b_gap_idle", 80'(bus.busy), 80'd0);
        @(negedge clk);
        acc = cyc;
        bus.req = 1'b0;
        check("b2b_b_busy", 80'(bus.busy), 80'd1);
        wait_ack(lat);
        check("b2b_b_lat", 80'(lat), 80'd63);
        check("b2b_b_M", 80'(bus.M), 80'hffffffffffffffff);

        // reset abort at e40
        start(80'h0, 64'h5579c1387b228445, 1'b0);
        acks_before = ack_count;
        while (cyc - acc < 39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 80'(bus.busy), 80'd0);
        check("abort_M", 80'(bus.M), 80'd0);
        check("abort_ack", 80'(bus.ack), 80'd0);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check("abort_no_ack", 80'(ack_count), 80'(acks_before));
        check("abort_M_hold", 80'(bus.M), 80'd0);
        start(80'h0, 64'ha112ffc72f68417b, 1'b0);
        wait_ack(lat);
        check("post_abort_lat", 80'(lat), 80'd63);
        check("post_abort_M", 80'(bus.M), 80'hffffffffffffffff);

        // request pulsed and inputs changed during DEC must be ignored
        @(negedge clk);
        start(80'h0, 64'h5579c1387b228445, 1'b0);
        acks_before = ack_count;
        while (cyc - acc < 40) @(negedge clk);
        check("dec_M_hold", 80'(bus.M), 80'hffffffffffffffff);
        bus.req = 1'b1;
        bus.K = {80{1'b1}};
        bus.C = 64'ha112ffc72f68417b;
        @(negedge clk);
        bus.req = 1'b0;
        wait_ack(lat);
        check("ign_lat", 80'(lat), 80'd63);
        check("ign_M", 80'(bus.M), 80'h0);
        repeat (5) @(negedge clk);
        check("ign_one_ack", 80'(ack_count), 80'(acks_before + 1));
        check("ign_idle", 80'(bus.busy), 80'd0);

        for (int n = 0; n < 8; n++) begin
            rk = {$urandom(), $urandom(), 16'($urandom())};
            rp = {$urandom(), $urandom()};
            start(rk, present_enc(rk, rp), 1'b0);
            wait_ack(lat);
            check($sformatf("rand%0d_lat", n), 80'(lat), 80'd63);
            check($sformatf("rand%0d_M", n), 80'(bus.M), 80'(rp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
